piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 121 ++++++++++++
 tb/tb_piso_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out converter with a one-word holding register so that
// consecutive words stream out with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             x_nxt, x_valid_nxt, word_done_nxt, busy_nxt;
  logic             xfer, load;
  logic [WIDTH-1:0] load_word;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready = ~hold_full & rstn;
  assign xfer      = din_valid & din_ready;

  // sreg holds the bits not yet presented; the bit on x lives in the x register.
  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    hold_nxt      = hold;
    cnt_nxt       = cnt;
    hold_full_nxt = hold_full;
    x_nxt         = 1'b0;
    x_valid_nxt   = 1'b0;
    word_done_nxt = 1'b0;
    busy_nxt      = 1'b0;
    load          = 1'b0;
    load_word     = din;
    case (state)
      IDLE: begin
        if (xfer) load = 1'b1;
      end
      SHIFT: begin
        if (cnt != LAST) begin
          x_nxt         = head_bit(sreg);
          sreg_nxt      = advance(sreg);
          cnt_nxt       = cnt + 1'b1;
          x_valid_nxt   = 1'b1;
          busy_nxt      = 1'b1;
          word_done_nxt = (cnt == PRE_LAST);
          if (xfer) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          load          = 1'b1;
          load_word     = hold;
          hold_full_nxt = 1'b0;
        end else if (xfer) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      state_nxt     = SHIFT;
      sreg_nxt      = advance(load_word);
      cnt_nxt       = '0;
      x_nxt         = head_bit(load_word);
      x_valid_nxt   = 1'b1;
      busy_nxt      = 1'b1;
      word_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      hold      <= hold_nxt;
      cnt       <= cnt_nxt;
      hold_full <= hold_full_nxt;
      x         <= x_nxt;
      x_valid   <= x_valid_nxt;
      word_done <= word_done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances checked every
// cycle against a bit-queue model, plus directed scenarios with literal results.
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy_m, x_m, xv_m, wd_m, busy_m;
  logic         rdy_l, x_l, xv_l, wd_l, busy_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(busy_m));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(busy_l));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of {last, bit} still to appear on x; head is the bit on x now.
  bit [1:0] qm[$];
  bit [1:0] ql[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qm.delete();
      ql.delete();
    end else begin
      bit acc;
      acc = din_valid && (qm.size() <= W);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++) begin
          qm.push_back({k == W - 1, din[W-1-k]});
          ql.push_back({k == W - 1, din[k]});
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("msb x_valid", xv_m, qm.size() > 0);
    chk("msb x", x_m, (qm.size() > 0) ? qm[0][0] : 1'b0);
    chk("msb word_done", wd_m, (qm.size() > 0) ? qm[0][1] : 1'b0);
    chk("msb busy", busy_m, qm.size() > 0);
    chk("msb din_ready", rdy_m, rstn && (qm.size() <= W));
    chk("lsb x_valid", xv_l, ql.size() > 0);
    chk("lsb x", x_l, (ql.size() > 0) ? ql[0][0] : 1'b0);
    chk("lsb word_done", wd_l, (ql.size() > 0) ? ql[0][1] : 1'b0);
    chk("lsb busy", busy_l, ql.size() > 0);
    chk("lsb din_ready", rdy_l, rstn && (ql.size() <= W));
  end

  task automatic run_one(input logic [7:0] a);
    din = a;
    din_valid = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      chk("one msb x_valid", xv_m, i < 8);
      chk("one msb busy", busy_m, i < 8);
      chk("one msb word_done", wd_m, i == 7);
      chk("one lsb x_valid", xv_l, i < 8);
      if (i < 8) begin
        chk("one msb x", x_m, a[7-i]);
        chk("one lsb x", x_l, a[i]);
      end else begin
        chk("one msb x idle", x_m, 1'b0);
      end
    end
  endtask

  task automatic run_two(input logic [7:0] a, input logic [7:0] b, input int offer_at,
                         input bit scramble, input string tag);
    din = a;
    din_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      chk({tag, " x_valid"}, xv_m, i < 16);
      if (i < 16) begin
        chk({tag, " x"}, x_m, (i < 8) ? a[7-i] : b[15-i]);
        chk({tag, " word_done"}, wd_m, (i == 7) || (i == 15));
        chk({tag, " din_ready"}, rdy_m, (offer_at == 0) ? !(i >= 1 && i <= 7) : 1'b1);
      end
      if (i == offer_at) begin
        din = b;
        din_valid = 1'b1;
      end else if (scramble && i > offer_at && i < 7) begin
        din = 8'($urandom);
      end else begin
        din_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    chk("reset x", x_m, 1'b0);
    chk("reset x_valid", xv_m, 1'b0);
    chk("reset word_done", wd_m, 1'b0);
    chk("reset busy", busy_m, 1'b0);
    chk("reset din_ready", rdy_m, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    #1 chk("ready after release", rdy_m, 1'b1);

    run_one(8'h66);
    run_one(8'h01);
    run_two(8'hA5, 8'h3C, 0, 1'b0, "b2b");
    run_two(8'h81, 8'hFF, 7, 1'b0, "bypass");
    run_two(8'hA5, 8'hC3, 0, 1'b1, "stall");

    // Asynchronous reset in the middle of a word.
    din = 8'hF0;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("midrst first bit", x_m, 1'b1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst x", x_m, 1'b0);
    chk("midrst x_valid", xv_m, 1'b0);
    chk("midrst word_done", wd_m, 1'b0);
    chk("midrst busy", busy_m, 1'b0);
    chk("midrst din_ready", rdy_m, 1'b0);
    chk("midrst lsb x_valid", xv_l, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst quiet x_valid", xv_m, 1'b0);
      chk("midrst quiet x", x_m, 1'b0);
    end

    // Randomized traffic with varying offer density and rare reset pulses.
    for (int c = 0; c < 3000; c++) begin
      int thr;
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
      end
      thr = ((c / 500) % 3 == 0) ? 3 : (((c / 500) % 3 == 1) ? 7 : 10);
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 9) < thr);
    end
    din_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
